// File: rtl/proc_pkg.sv
// Shared definitions for the processor preload/run sequencer.
package proc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    RUN,
    DONE
  } seq_state_t;

  localparam int unsigned SETTLE_CYCLES_DEF  = 2;
  localparam int unsigned TIMEOUT_CYCLES_DEF = 5000;

endpackage

// File: rtl/sat_cycle_counter.sv
// Saturating 32-bit run-cycle counter; tc_o flags that the next counted cycle reaches LIMIT.
// One cycle from en_i to count_o; clear_i has priority over en_i.
module sat_cycle_counter #(
  parameter int unsigned LIMIT = 5000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear_i,
  input  logic        en_i,
  output logic [31:0] count_o,
  output logic        tc_o
);

  logic [31:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (en_i && (count_q != 32'hFFFF_FFFF)) begin
      count_d = count_q + 32'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // Widened compare so the +1 never wraps at saturation.
  assign tc_o    = ({1'b0, count_q} + 33'd1) >= 33'(LIMIT);
  assign count_o = count_q;

endmodule

// File: rtl/imem_load_sequencer.sv
// Preloads a word stream into processor memory, holds the CPU in reset to settle, then runs it until a0 matches or a timeout.
// Writes are combinational with the wr_valid/wr_ready handshake; host backpressure simply stalls LOAD.
module imem_load_sequencer
  import proc_pkg::*;
#(
  parameter int unsigned WIDTH          = 32,
  parameter int unsigned ADDR_STEP      = 4,
  parameter int unsigned SETTLE_CYCLES  = SETTLE_CYCLES_DEF,
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      num_words,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [WIDTH-1:0] expected_a0,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic             memEn,
  output logic [WIDTH-1:0] memAddr,
  output logic [WIDTH-1:0] memData,
  output logic             cpu_reset,
  input  logic [WIDTH-1:0] a0,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic [31:0]      cycles
);

  seq_state_t       state_q, state_d;
  logic [WIDTH-1:0] addr_q, addr_d;
  logic [WIDTH-1:0] expected_q, expected_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [15:0]      num_words_q, num_words_d;
  logic [31:0]      settle_q, settle_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             timeout_q, timeout_d;

  logic start_ok;
  logic accept;
  logic run_tc;

  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));
  assign accept   = (state_q == LOAD) && wr_valid;

  // cycles equals the number of cycles spent in RUN, including the cycle whose
  // a0 compare ends the run: a match seen in the 37th RUN cycle reports 37.
  sat_cycle_counter #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_run_cnt (
    .clock  (clock),
    .reset  (reset),
    .clear_i(start_ok),
    .en_i   (state_q == RUN),
    .count_o(cycles),
    .tc_o   (run_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    expected_d  = expected_q;
    word_cnt_d  = word_cnt_q;
    num_words_d = num_words_q;
    settle_d    = settle_q;
    done_d      = done_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          num_words_d = num_words;
          expected_d  = expected_a0;
          addr_d      = base_addr;
          word_cnt_d  = '0;
          settle_d    = '0;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          timeout_d   = 1'b0;
          state_d     = (num_words == 16'd0) ? SETTLE : LOAD;
        end
      end
      LOAD: begin
        if (wr_valid) begin
          addr_d     = addr_q + WIDTH'(ADDR_STEP);
          word_cnt_d = word_cnt_q + 16'd1;
          if (word_cnt_q == (num_words_q - 16'd1)) begin
            state_d = SETTLE;
          end
        end
      end
      SETTLE: begin
        // A zero setting still spends the one mandatory SETTLE cycle.
        if ((settle_q + 32'd1) >= SETTLE_CYCLES) begin
          state_d = RUN;
        end else begin
          settle_d = settle_q + 32'd1;
        end
      end
      RUN: begin
        if (a0 == expected_q) begin
          state_d = DONE;
          done_d  = 1'b1;
          pass_d  = 1'b1;
        end else if (run_tc) begin
          state_d   = DONE;
          done_d    = 1'b1;
          timeout_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      expected_q  <= '0;
      word_cnt_q  <= '0;
      num_words_q <= '0;
      settle_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      expected_q  <= expected_d;
      word_cnt_q  <= word_cnt_d;
      num_words_q <= num_words_d;
      settle_q    <= settle_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
    end
  end

  assign wr_ready  = (state_q == LOAD);
  assign memEn     = accept;
  assign memAddr   = accept ? addr_q : '0;
  assign memData   = accept ? wr_data : '0;
  assign cpu_reset = (state_q != RUN);
  assign busy      = (state_q == LOAD) || (state_q == SETTLE) || (state_q == RUN);
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_imem_load_sequencer.sv
// Scoreboard bench: stimulus queues expected writes/results, a negedge monitor compares them.
module tb_imem_load_sequencer;

  localparam int T = 40;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] num_words = '0;
  logic [31:0] base_addr = '0;
  logic [31:0] expected_a0 = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] a0 = '0;
  logic        wr_ready, memEn, cpu_reset, busy, done, pass, timeout;
  logic [31:0] memAddr, memData, cycles;

  imem_load_sequencer #(
    .WIDTH(32), .ADDR_STEP(4), .SETTLE_CYCLES(2), .TIMEOUT_CYCLES(T)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .num_words(num_words),
    .base_addr(base_addr), .expected_a0(expected_a0), .wr_valid(wr_valid),
    .wr_data(wr_data), .wr_ready(wr_ready), .memEn(memEn), .memAddr(memAddr),
    .memData(memData), .cpu_reset(cpu_reset), .a0(a0), .busy(busy),
    .done(done), .pass(pass), .timeout(timeout), .cycles(cycles)
  );

  always #5 clock = ~clock;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  typedef struct { logic pass; logic tmo; logic [31:0] cyc; } res_t;

  wr_t  wq[$];
  res_t rq[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bounded wait expired", name);
  endtask

  // Monitor: pops expected writes on every memEn and expected results on done rising.
  initial begin
    logic done_prev;
    int   settle_len;
    wr_t  e;
    res_t r;
    done_prev  = 1'b0;
    settle_len = 0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        done_prev  = 1'b0;
        settle_len = 0;
      end else begin
        if (memEn) begin
          chk("write_only_with_valid", {31'd0, wr_valid}, 32'd1);
          if (wq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", memAddr, memData);
          end else begin
            e = wq.pop_front();
            chk("memAddr", memAddr, e.addr);
            chk("memData", memData, e.data);
          end
        end
        if (busy && cpu_reset && !wr_ready) begin
          settle_len++;
        end else if (settle_len != 0) begin
          chk("settle_len", settle_len, 32'd2);
          chk("cpu_reset_low_after_settle", {31'd0, cpu_reset}, 32'd0);
          settle_len = 0;
        end
        if (done && !done_prev) begin
          if (rq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: pass %0d timeout %0d, no session pending", pass, timeout);
          end else begin
            r = rq.pop_front();
            chk("pass", {31'd0, pass}, {31'd0, r.pass});
            chk("timeout", {31'd0, timeout}, {31'd0, r.tmo});
            chk("cycles", cycles, r.cyc);
            chk("cpu_reset_in_done", {31'd0, cpu_reset}, 32'd1);
          end
        end
        done_prev = done;
      end
    end
  end

  // One load/run session. match_at is the 1-based RUN cycle where a0 matches (0 = never).
  task automatic session(input logic [31:0] base, input int n, input bit gaps,
                         input logic [31:0] w0, input bit seq, input logic [31:0] exp,
                         input int match_at, input bit start_in_load, input bit start_in_run);
    logic [31:0] words[$];
    res_t r;
    int   k;
    for (int i = 0; i < n; i++) begin
      words.push_back(seq ? w0 + 32'(i) : $urandom);
      wq.push_back('{base + 32'(4 * i), words[i]});
    end
    r.pass = (match_at != 0) && (match_at <= T);
    r.tmo  = !r.pass;
    r.cyc  = r.pass ? 32'(match_at) : 32'(T);
    rq.push_back(r);
    a0 = ~exp;

    base_addr = base; num_words = 16'(n); expected_a0 = exp; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    base_addr = $urandom; num_words = 16'($urandom); expected_a0 = ~exp;
    chk("done_cleared_on_start", {31'd0, done}, 32'd0);
    chk("pass_cleared_on_start", {31'd0, pass}, 32'd0);
    chk("cycles_cleared_on_start", cycles, 32'd0);
    chk("cpu_reset_after_start", {31'd0, cpu_reset}, 32'd1);

    for (int i = 0; i < n; i++) begin
      if (gaps && i > 0) begin
        wr_valid = 1'b0;
        wr_data  = $urandom;
        if (start_in_load && i == 1) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
      end
      wr_valid = 1'b1;
      wr_data  = words[i];
      chk("wr_ready_in_load", {31'd0, wr_ready}, 32'd1);
      @(posedge clock); #1;
    end
    wr_valid = 1'b0;
    chk("wr_ready_after_last", {31'd0, wr_ready}, 32'd0);

    k = 0;
    while (cpu_reset && k < 50) begin
      @(posedge clock); #1;
      k++;
    end
    if (cpu_reset) begin
      fail_now("run_entry");
    end else begin
      for (int c = 1; c <= T + 5; c++) begin
        a0 = (c == match_at) ? exp : ~exp;
        if (start_in_run && c == 2) start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        if (done) break;
      end
      a0 = ~exp;
      if (!done) fail_now("done_wait");
    end
    @(posedge clock); #1;
    chk("done_held", {31'd0, done}, 32'd1);
    chk("busy_low_in_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    #12;
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd0);
    chk("rst_memEn", {31'd0, memEn}, 32'd0);
    chk("rst_memAddr", memAddr, 32'd0);
    chk("rst_memData", memData, 32'd0);
    chk("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_pass", {31'd0, pass}, 32'd0);
    chk("rst_timeout", {31'd0, timeout}, 32'd0);
    chk("rst_cycles", cycles, 32'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    session(32'h100, 3, 1'b0, 32'hA, 1'b1, 32'd144, 37, 1'b0, 1'b0);
    session(32'h200, 3, 1'b1, 32'h0, 1'b0, $urandom, 5, 1'b1, 1'b0);
    session(32'h400, 2, 1'b0, 32'h0, 1'b0, $urandom, 0, 1'b0, 1'b0);
    session(32'h500, 1, 1'b0, 32'h0, 1'b0, $urandom, T, 1'b0, 1'b0);
    session(32'h600, 0, 1'b0, 32'h0, 1'b0, $urandom, 4, 1'b0, 1'b1);

    // Reset mid-load: two words land, the third is on the bus as reset asserts.
    base_addr = 32'h300; num_words = 16'd4; expected_a0 = 32'h55; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      w = $urandom;
      wq.push_back('{32'h300 + 32'(4 * i), w});
      wr_valid = 1'b1;
      wr_data  = w;
      @(posedge clock); #1;
    end
    wr_data = $urandom;
    #2;
    reset = 1'b0;
    #1;
    chk("abort_memEn", {31'd0, memEn}, 32'd0);
    chk("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_wr_ready", {31'd0, wr_ready}, 32'd0);
    wr_valid = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    chk("abort_writes_drained", 32'(wq.size()), 32'd0);
    session(32'h300, 4, 1'b0, 32'h0, 1'b0, $urandom, 3, 1'b0, 1'b1);

    for (int s = 0; s < 6; s++) begin
      session($urandom & 32'hFFFF_FFFC, $urandom_range(0, 6), 1'($urandom_range(0, 1)),
              32'h0, 1'b0, $urandom, $urandom_range(0, T + 5),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    @(posedge clock); #1;
    chk("writes_all_seen", 32'(wq.size()), 32'd0);
    chk("results_all_seen", 32'(rq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imem_load_sequencer.md
IMEM_LOAD_SEQUENCER -- requirements
Module: imem_load_sequencer

Interface
REQ-001 Parameter WIDTH, default 32: data/address width of the processor preload port.
REQ-002 Parameter ADDR_STEP, default 4: byte increment of memAddr per loaded word.
REQ-003 Parameter SETTLE_CYCLES, default 2: cycles cpu_reset stays asserted after the last word is written.
REQ-004 Parameter TIMEOUT_CYCLES, default 5000: maximum run cycles before a timeout is declared.
REQ-005 Ports:
- clock  in  1: single clock, rising edge.
- reset  in  1: asynchronous, active-low.
- start  in  1: one-cycle pulse that begins a load/run session; honoured only in IDLE or DONE.
- num_words  in  16: number of words to load (sampled on start).
- base_addr  in  WIDTH: first preload address (sampled on start).
- expected_a0  in  WIDTH: pass value for a0 (sampled on start).
- wr_valid  in  1: host word available.
- wr_data  in  WIDTH: host word.
- wr_ready  out  1: sequencer accepts the word this cycle.
- memEn  out  1: processor preload write enable.
- memAddr  out  WIDTH: processor preload address.
- memData  out  WIDTH: processor preload data.
- cpu_reset  out  1: active-high reset to the processor.
- a0  in  WIDTH: processor a0 observation.
- busy  out  1: high in LOAD, SETTLE and RUN.
- done  out  1: session finished; held until the next start.
- pass  out  1: a0 matched expected_a0.
- timeout  out  1: run exceeded TIMEOUT_CYCLES.
- cycles  out  32: run-cycle count.

Function
REQ-006 The FSM SHALL have the states IDLE, LOAD, SETTLE, RUN and DONE.
REQ-007 IDLE/DONE + start: if num_words=0, go to SETTLE, otherwise go to LOAD. On start, clear done, pass, timeout and cycles, and load the address counter with base_addr.
REQ-008 LOAD: wr_ready=1. On wr_valid&&wr_ready, memEn=1, memData=wr_data and memAddr=the current address; all three are combinational in the same cycle. The address then advances by ADDR_STEP and the word counter increments.
REQ-009 LOAD: when the accepted word is the num_words-th word, go to SETTLE on the next edge; no further wr_ready is asserted.
REQ-010 LOAD: if wr_valid=0, stay in LOAD with memEn=0; there is no timeout while loading.
REQ-011 memEn SHALL be 0 in every state other than LOAD.
REQ-012 cpu_reset SHALL be 1 in IDLE, LOAD, SETTLE and DONE, and 0 only in RUN.
REQ-013 SETTLE: stay exactly SETTLE_CYCLES cycles, then go to RUN. If SETTLE_CYCLES=0, the transition is immediate on the next edge.
REQ-014 RUN: cycles increments by 1 every cycle, saturating at 2^32-1.
REQ-015 RUN: if a0==expected_a0, go to DONE with pass=1 and done=1. The check is registered: the compare is sampled at the edge and takes effect in that transition.
REQ-016 RUN: if cycles reaches TIMEOUT_CYCLES without a match, go to DONE with timeout=1 and done=1.
REQ-017 If a match and the timeout occur in the same cycle, match wins: pass=1, timeout=0.
REQ-018 start in LOAD, SETTLE or RUN SHALL be ignored.
REQ-019 start in DONE SHALL begin a new session (REQ-007), and cpu_reset remains 1 throughout.
REQ-020 pass and timeout SHALL be mutually exclusive and change only on entry to DONE or on start.

Reset
REQ-021 Asserting reset SHALL force IDLE asynchronously, from any state including mid-LOAD or mid-RUN.
REQ-022 Reset values: wr_ready=0, memEn=0, memAddr=0, memData=0, cpu_reset=1, busy=0, done=0, pass=0, timeout=0, cycles=0, and the internal address and word counters at 0.
REQ-023 A word presented on the cycle reset asserts SHALL NOT be written.

Structure
REQ-024 The state enum (seq_state_t) and the defaults for SETTLE_CYCLES and TIMEOUT_CYCLES SHALL live in the shared package proc_pkg.
REQ-025 The run-cycle counter with saturation and terminal-count flag SHALL be one sub-module, sat_cycle_counter, and everything else SHALL be flat in imem_load_sequencer.

Verification
REQ-026 Load 3 words 0xA, 0xB, 0xC at base 0x100 with wr_valid held -> memEn on 3 consecutive cycles with memAddr 0x100, 0x104, 0x108; SETTLE lasts 2 cycles with cpu_reset=1; cpu_reset falls.
REQ-027 Toggle wr_valid 1,0,1,0,1 for 3 words -> exactly 3 writes, memEn=0 on the gap cycles, and the addresses are contiguous.
REQ-028 expected_a0=144, model drives a0=144 at run cycle 37 -> done=1, pass=1, timeout=0, cycles=37 or 38 (document the exact value per REQ-015), and cpu_reset returns to 1.
REQ-029 TIMEOUT_CYCLES=10, a0 never matches -> done=1, timeout=1, pass=0, cycles=10; match and timeout on the same cycle -> pass=1, timeout=0.
REQ-030 Assert reset after the 2nd of 4 words -> immediate IDLE, memEn=0, cpu_reset=1; a new start reloads from base_addr.
REQ-031 num_words=0 -> no memEn pulses, SETTLE then RUN; start pulses during LOAD and RUN are ignored.
